// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder.
// Size codes, MMIO register offsets, STATUS bits.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  localparam logic [3:0] LED_OFF   = 4'h0;
  localparam logic [3:0] CYCLO_OFF = 4'h4;
  localparam logic [3:0] CYCHI_OFF = 4'h8;
  localparam logic [3:0] STAT_OFF  = 4'hC;

  localparam int STAT_MISALIGN = 0;
  localparam int STAT_RANGE    = 1;

  // Code 2'b11 is treated as a word access.
  function automatic size_e decode_size(
    input logic [1:0] s
  );
    unique case (s)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_align.sv
// load_align_ext: lane select plus sign/zero extension.
// Ports: word in, byte offset, size, zext -> data out.
module load_align_ext
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        zext,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[{off, 3'b000} +: 8];
    h    = off[1] ? word[31:16] : word[15:0];
    data = word;
    unique case (size)
      SZ_BYTE: data = {{24{~zext & b[7]}}, b};
      SZ_HALF: data = {{16{~zext & h[15]}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory target: byte-lane RAM, aligned loads, MMIO regs.
// Ports: clk_i/reset_i, CPU data port, led_o, err_o.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h2000_0000,
  parameter int          LED_WIDTH   = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [31:0]          data_mem_addr,
  input  logic [31:0]          data_mem_WrData,
  input  logic                 data_mem_memwrite,
  input  logic                 data_mem_memread,
  input  logic [2:0]           data_mem_sign_mask,
  output logic [31:0]          data_mem_out,
  output logic [LED_WIDTH-1:0] led_o,
  output logic                 err_o
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  size_e          size;
  size_e          size_q;
  logic           zext;
  logic           zext_q;
  logic           in_ram;
  logic           in_mmio;
  logic           misalign;
  logic           range_err;
  logic           ok;
  logic           acc;
  logic           ld_ok;
  logic           st_ok;
  logic [3:0]     moff;
  logic [AW-1:0]  widx;
  logic [3:0]     be;
  logic [31:0]    wlane;
  logic [31:0]    mmio_rd;
  logic [31:0]    rd_word;
  logic [31:0]    rword_q;
  logic [1:0]     off_q;
  logic [63:0]    cyc_q;
  logic [31:0]    snap_q;
  logic [LED_WIDTH-1:0] led_q;
  logic [1:0]     flags_q;
  logic [1:0]     flag_set;
  logic [1:0]     flag_clr;
  logic           err_q;

  assign size      = decode_size(data_mem_sign_mask[1:0]);
  assign zext      = data_mem_sign_mask[2];
  assign in_ram    = data_mem_addr < RAM_BYTES;
  assign in_mmio   = data_mem_addr[31:4] == MMIO_BASE[31:4];
  assign moff      = data_mem_addr[3:0];
  assign widx      = data_mem_addr[AW+1:2];
  assign acc       = data_mem_memread | data_mem_memwrite;
  assign range_err = ~in_ram & ~in_mmio;
  assign ok        = ~misalign & ~range_err;
  assign ld_ok     = data_mem_memread & ok;
  assign st_ok     = data_mem_memwrite & ok;

  // MMIO registers only accept whole-word accesses.
  always_comb begin
    misalign = 1'b0;
    unique case (size)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = data_mem_addr[0];
      default: misalign = |data_mem_addr[1:0];
    endcase
    if (in_mmio && size != SZ_WORD) misalign = 1'b1;
  end

  always_comb begin
    be    = 4'b0000;
    wlane = data_mem_WrData;
    unique case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << data_mem_addr[1:0];
        wlane = {4{data_mem_WrData[7:0]}};
      end
      SZ_HALF: begin
        be    = data_mem_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{data_mem_WrData[15:0]}};
      end
      default: be = 4'b1111;
    endcase
    if (!(st_ok && in_ram)) be = 4'b0000;
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
    end
  end

  always_comb begin
    mmio_rd = '0;
    unique case (moff)
      LED_OFF:   mmio_rd = 32'(led_q);
      CYCLO_OFF: mmio_rd = cyc_q[31:0];
      CYCHI_OFF: mmio_rd = snap_q;
      STAT_OFF:  mmio_rd = {30'b0, flags_q};
      default:   mmio_rd = '0;
    endcase
  end

  // A suppressed load latches zero, which extends to zero.
  always_comb begin
    rd_word = '0;
    if (ld_ok) rd_word = in_mmio ? mmio_rd : mem[widx];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rword_q <= '0;
      off_q   <= '0;
      size_q  <= SZ_WORD;
      zext_q  <= 1'b0;
    end else if (data_mem_memread) begin
      rword_q <= rd_word;
      off_q   <= data_mem_addr[1:0];
      size_q  <= size;
      zext_q  <= zext;
    end
  end

  load_align_ext u_align (
    .word (rword_q),
    .off  (off_q),
    .size (size_q),
    .zext (zext_q),
    .data (data_mem_out)
  );

  assign flag_set[STAT_MISALIGN] = acc & misalign;
  assign flag_set[STAT_RANGE]    = acc & range_err;
  assign flag_clr = (st_ok && in_mmio && moff == STAT_OFF)
                  ? data_mem_WrData[1:0] : 2'b00;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cyc_q   <= '0;
      snap_q  <= '0;
      led_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cyc_q <= cyc_q + 64'd1;
      if (ld_ok && in_mmio && moff == CYCLO_OFF) snap_q <= cyc_q[63:32];
      if (st_ok && in_mmio && moff == LED_OFF)
        led_q <= data_mem_WrData[LED_WIDTH-1:0];
      // Set beats clear when both hit in one cycle.
      flags_q <= (flags_q & ~flag_clr) | flag_set;
      err_q   <= |flags_q;
    end
  end

  assign led_o = led_q;
  assign err_o = err_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Target side of the CPU data-memory interface. It services the load and store strobes that the EX stage issues.
- Contents: a word-organised synchronous RAM with byte-lane writes, load alignment and sign/zero extension, and a small memory-mapped register file (LED, cycle counter, error status).
- Sits between the CPU's data port and the board I/O. Load data returns in the CPU's MA stage, one cycle after the request.

Parameters:
- DEPTH_WORDS, 1024, RAM size in 32-bit words; power of two.
- MMIO_BASE, 32'h2000_0000, base address of the register window; aligned to 16 bytes.
- LED_WIDTH, 8, width of the LED register.

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge.
- reset_i  in  1  synchronous reset, active-high.
- data_mem_addr  in  32  byte address, valid in the request cycle.
- data_mem_WrData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- data_mem_memwrite  in  1  store strobe, one cycle per store.
- data_mem_memread  in  1  load strobe, one cycle per load.
- data_mem_sign_mask  in  3  [1:0] size: 00 byte, 01 half, 10 word (11 treated as word). [2]: 1 = zero-extend (LBU/LHU).
- data_mem_out  out  32  aligned, extended load result, valid the cycle after data_mem_memread.
- led_o  out  LED_WIDTH  LED register contents.
- err_o  out  1  OR of the sticky error flags.

Behaviour:
- Reset:
  - led_o=0, err_o=0, data_mem_out=0, cycle counter=0, CYCLE_HI snapshot=0, error flags=0.
  - RAM contents are not cleared.
- Address decode:
  - RAM region: addr < 4*DEPTH_WORDS.
  - MMIO region: addr[31:4]==MMIO_BASE[31:4].
  - Anything else is out-of-range.
- Stores (memwrite=1), RAM region:
  - Written at the same rising edge; byte enables are derived from size and addr[1:0].
  - Byte: lane addr[1:0] gets WrData[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} get WrData[15:0].
  - Word: all four lanes.
  - Other lanes are preserved. No read-modify-write cycle and no stall.
- Loads (memread=1), one-cycle latency:
  - Edge N registers the RAM word (or MMIO value), addr[1:0], the size and the extend bit.
  - In cycle N+1, data_mem_out is a combinational function of those registers: lane select, then sign extension (bit 7 or 15) or zero extension.
  - If no load was issued in cycle N, data_mem_out holds the last load result.
- Store-then-load to the same word on consecutive cycles returns the new data (write happens at edge N, read at edge N+1).
- memread and memwrite asserted together: the store is performed, the load returns the pre-store word, and no error is flagged.
- Misalignment:
  - Half with addr[0]=1, or word with addr[1:0]!=0.
  - Access is suppressed: a store writes nothing, a load returns 0.
  - Sticky MISALIGN flag is set.
- Out-of-range access: suppressed, load returns 0, sticky RANGE flag is set.
- MMIO registers (word access only; sub-word MMIO access is treated as misaligned):
  - +0x0 LED: read/write, low LED_WIDTH bits, upper bits read 0.
  - +0x4 CYCLE_LO: read-only. Reading it also captures counter[63:32] into the CYCLE_HI snapshot at that same edge.
  - +0x8 CYCLE_HI: read-only, returns the snapshot.
  - +0xC STATUS: bit0 MISALIGN, bit1 RANGE. Write-1-to-clear.
  - Writes to read-only registers are ignored with no error.
- Cycle counter: 64 bits, increments every cycle after reset, wraps from 2^64-1 to 0 silently.
- Error flags:
  - Set and clear in the same cycle: set wins.
  - err_o is registered, so it follows the flags by one cycle.
- Reset mid-operation: a load in flight is discarded; data_mem_out is 0 in the cycle after reset.

Decomposition:
- Shared package:
  - Size encodings SZ_BYTE / SZ_HALF / SZ_WORD.
  - MMIO offsets LED_OFF / CYCLO_OFF / CYCHI_OFF / STAT_OFF.
  - STATUS bit indices.
- Sub-module load_align_ext: combinational lane select plus extension, shared with any future instruction-side byte loader.
- The RAM is inferred inside the block as a byte-enabled array.

Test Plan:
- Store word 0xDEADBEEF at 0x10, then loads on the next cycles:
  - LB at 0x13 -> 0xFFFFFFDE.
  - LBU at 0x13 -> 0x000000DE.
  - LH at 0x12 -> 0xFFFFDEAD.
  - LHU at 0x10 -> 0x0000BEEF.
- Word 0xDEADBEEF at 0x10, then SB 0x55 at 0x11, then LW 0x10 on the next cycle -> 0xDEAD55EF; SH 0x1234 at 0x12 then LW -> 0x123455EF.
- LW at 0x11:
  - data_mem_out=0 in the next cycle and err_o=1 one cycle later.
  - RAM word unchanged.
  - Write 0x1 to MMIO_BASE+0xC -> err_o=0 two cycles later.
- SW 0xA5 to MMIO_BASE -> led_o=0xA5 at the next edge; SB to MMIO_BASE -> misaligned, led_o unchanged, STATUS bit0=1.
- Preload the counter to 0x0000_0000_FFFF_FFFE via force, read CYCLE_LO, then CYCLE_HI two cycles later:
  - CYCLE_HI returns 0 (snapshot), not 1.
  - Separately, verify the 2^64 wrap.
- Assert reset_i in the cycle of a load -> data_mem_out=0 the next cycle; led_o and flags cleared; RAM data written before reset still readable after.
